// File: rtl/head_lookup_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : head_lookup_pkg
//  Description : Shared widths, tag bit positions, rule record and packet
//                state for the head/meta shift lookup stage.
//  Revision    : 1.0  initial release
// ============================================================================
`ifndef HEAD_WIDTH
`define HEAD_WIDTH 128
`endif
`ifndef META_WIDTH
`define META_WIDTH 32
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 4
`endif
`ifndef HEAD_SHIFT_WIDTH
`define HEAD_SHIFT_WIDTH 6
`endif
`ifndef META_SHIFT_WIDTH
`define META_SHIFT_WIDTH 4
`endif
// Tag bit positions within the tag field, which sits above the data bits.
`ifndef TAG_VALID
`define TAG_VALID 0
`endif
`ifndef TAG_START
`define TAG_START 1
`endif
`ifndef TAG_TAIL
`define TAG_TAIL 2
`endif
`ifndef TAG_SHIFT
`define TAG_SHIFT 3
`endif

package head_lookup_pkg;
  localparam int HEAD_W        = `HEAD_WIDTH;
  localparam int META_W        = `META_WIDTH;
  localparam int TAG_W         = `TAG_WIDTH;
  localparam int HS_W          = `HEAD_SHIFT_WIDTH;
  localparam int MS_W          = `META_SHIFT_WIDTH;
  localparam int TAG_VALID_BIT = `TAG_VALID;
  localparam int TAG_START_BIT = `TAG_START;
  localparam int TAG_TAIL_BIT  = `TAG_TAIL;
  localparam int TAG_SHIFT_BIT = `TAG_SHIFT;
  localparam int LKP_KEY_WIDTH = 16;
  localparam int LKP_RULE_NUM  = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_e;

  typedef struct packed {
    logic                     valid;
    logic [LKP_KEY_WIDTH-1:0] key;
    logic [LKP_KEY_WIDTH-1:0] mask;
    logic [HS_W-1:0]          head_shift;
    logic [MS_W-1:0]          meta_shift;
  } rule_t;
endpackage
`default_nettype wire

// File: rtl/head_shift_lookup_if.sv
`default_nettype none
// ============================================================================
//  Module      : head_shift_lookup_if
//  Description : Tagged head/meta stream in and out of the lookup stage,
//                with the per-packet shift results.
//  Revision    : 1.0  initial release
// ============================================================================
interface head_shift_lookup_if;
  import head_lookup_pkg::*;

  logic [HEAD_W+TAG_W-1:0] i_head;
  logic [META_W+TAG_W-1:0] i_meta;
  logic [HEAD_W+TAG_W-1:0] o_head;
  logic [META_W+TAG_W-1:0] o_meta;
  logic [HS_W-1:0]         o_headShift;
  logic [MS_W-1:0]         o_metaShift;
  logic                    o_hit;

  modport master (
    output i_head, i_meta,
    input  o_head, o_meta, o_headShift, o_metaShift, o_hit
  );

  modport slave (
    input  i_head, i_meta,
    output o_head, o_meta, o_headShift, o_metaShift, o_hit
  );
endinterface
`default_nettype wire

// File: rtl/head_lookup_match.sv
`default_nettype none
// ============================================================================
//  Module      : head_lookup_match
//  Description : Parallel masked key compare against every rule, and
//                lowest-index selection of the shift pair (default on miss).
//  Revision    : 1.0  initial release
// ============================================================================
module head_lookup_match
  import head_lookup_pkg::*;
#(
  parameter int RULE_NUM = LKP_RULE_NUM
) (
  input  logic [LKP_KEY_WIDTH-1:0] i_key,
  input  rule_t [RULE_NUM-1:0]     i_rules,
  input  logic [HS_W-1:0]          i_dflt_head_shift,
  input  logic [MS_W-1:0]          i_dflt_meta_shift,
  output logic [RULE_NUM-1:0]      o_hits,
  output logic [HS_W-1:0]          o_head_shift,
  output logic [MS_W-1:0]          o_meta_shift
);
  genvar g;
  generate
    for (g = 0; g < RULE_NUM; g++) begin : g_cmp
      assign o_hits[g] = i_rules[g].valid &
                         (((i_key ^ i_rules[g].key) & i_rules[g].mask) == '0);
    end
  endgenerate

  // Scanning from the top down leaves the lowest hitting index in place.
  always_comb begin
    o_head_shift = i_dflt_head_shift;
    o_meta_shift = i_dflt_meta_shift;
    for (int i = RULE_NUM - 1; i >= 0; i--) begin
      if (o_hits[i]) begin
        o_head_shift = i_rules[i].head_shift;
        o_meta_shift = i_rules[i].meta_shift;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/head_shift_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : head_shift_lookup
//  Description : Per-packet rule lookup producing head/meta shift amounts,
//                with the tagged stream delayed two cycles to line up.
//                Optional HEAD_LOOKUP_STAT_EN adds hit/miss counters.
//  Revision    : 1.0  initial release
// ============================================================================
module head_shift_lookup
  import head_lookup_pkg::*;
#(
  parameter int RULE_NUM   = LKP_RULE_NUM,
  parameter int KEY_WIDTH  = LKP_KEY_WIDTH,
  parameter int KEY_OFFSET = 12
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  head_shift_lookup_if.slave          bus,
  input  logic                        i_rule_wr,
  input  logic [$clog2(RULE_NUM)-1:0] i_rule_idx,
  input  logic                        i_rule_valid,
  input  logic [KEY_WIDTH-1:0]        i_rule_key,
  input  logic [KEY_WIDTH-1:0]        i_rule_mask,
  input  logic [HS_W-1:0]             i_rule_head_shift,
  input  logic [MS_W-1:0]             i_rule_meta_shift,
  input  logic                        i_dflt_wr,
  input  logic [HS_W-1:0]             i_dflt_head_shift,
  input  logic [MS_W-1:0]             i_dflt_meta_shift
`ifdef HEAD_LOOKUP_STAT_EN
  ,
  output logic [31:0]                 o_hit_cnt,
  output logic [31:0]                 o_miss_cnt
`endif
);
  localparam int HT      = HEAD_W + TAG_W;
  localparam int MT      = META_W + TAG_W;
  localparam int KEY_MSB = HEAD_W - 1 - 8 * KEY_OFFSET;

  rule_t [RULE_NUM-1:0] r_rules;
  logic [HS_W-1:0]      r_dflt_head_shift;
  logic [MS_W-1:0]      r_dflt_meta_shift;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rules           <= '0;
      r_dflt_head_shift <= '0;
      r_dflt_meta_shift <= '0;
    end else begin
      if (i_rule_wr) begin
        r_rules[i_rule_idx] <= '{valid:      i_rule_valid,
                                 key:        i_rule_key,
                                 mask:       i_rule_mask,
                                 head_shift: i_rule_head_shift,
                                 meta_shift: i_rule_meta_shift};
      end
      if (i_dflt_wr) begin
        r_dflt_head_shift <= i_dflt_head_shift;
        r_dflt_meta_shift <= i_dflt_meta_shift;
      end
    end
  end

  logic [KEY_WIDTH-1:0] w_key;
  logic                 w_in_lookup;
  logic [RULE_NUM-1:0]  w_hits;
  logic [HS_W-1:0]      w_sel_head_shift;
  logic [MS_W-1:0]      w_sel_meta_shift;

  assign w_key       = bus.i_head[KEY_MSB -: KEY_WIDTH];
  assign w_in_lookup = bus.i_head[HEAD_W+TAG_VALID_BIT] & bus.i_head[HEAD_W+TAG_START_BIT];

  head_lookup_match #(.RULE_NUM(RULE_NUM)) u_match (
    .i_key             (w_key),
    .i_rules           (r_rules),
    .i_dflt_head_shift (r_dflt_head_shift),
    .i_dflt_meta_shift (r_dflt_meta_shift),
    .o_hits            (w_hits),
    .o_head_shift      (w_sel_head_shift),
    .o_meta_shift      (w_sel_meta_shift)
  );

  // Stage 1: the selected shift pair is captured with the hits so that table
  // writes after the compare cycle cannot leak into this packet.
  logic [HT-1:0]       r1_head;
  logic [MT-1:0]       r1_meta;
  logic [RULE_NUM-1:0] r1_hits;
  logic [HS_W-1:0]     r1_head_shift;
  logic [MS_W-1:0]     r1_meta_shift;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r1_head       <= '0;
      r1_meta       <= '0;
      r1_hits       <= '0;
      r1_head_shift <= '0;
      r1_meta_shift <= '0;
    end else begin
      r1_head <= bus.i_head;
      r1_meta <= bus.i_meta;
      if (w_in_lookup) begin
        r1_hits       <= w_hits;
        r1_head_shift <= w_sel_head_shift;
        r1_meta_shift <= w_sel_meta_shift;
      end
    end
  end

  logic            w1_valid;
  logic            w1_start;
  logic            w1_tail;
  logic            w1_lookup;
  logic [HS_W-1:0] w_cur_head_shift;
  logic            w_tag_shift;
  logic [HT-1:0]   w_head_out;
  logic [MT-1:0]   w_meta_out;

  logic [HT-1:0]   r_head;
  logic [MT-1:0]   r_meta;
  logic [HS_W-1:0] r_head_shift;
  logic [MS_W-1:0] r_meta_shift;
  logic            r_hit;
  pkt_state_e      r_state;

  always_comb begin
    w1_valid         = r1_head[HEAD_W+TAG_VALID_BIT];
    w1_start         = r1_head[HEAD_W+TAG_START_BIT];
    w1_tail          = r1_head[HEAD_W+TAG_TAIL_BIT];
    w1_lookup        = w1_valid & w1_start;
    w_cur_head_shift = w1_lookup ? r1_head_shift : r_head_shift;
    // Stray non-start beats outside a packet never get the shift tag.
    w_tag_shift      = w1_valid & (w1_lookup | (r_state == IN_PKT)) &
                       (w_cur_head_shift != '0);
    w_head_out       = r1_head;
    w_head_out[HEAD_W+TAG_SHIFT_BIT] = w_tag_shift;
    w_meta_out       = r1_meta;
    w_meta_out[META_W+TAG_SHIFT_BIT] = w_tag_shift & r1_meta[META_W+TAG_VALID_BIT];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head       <= '0;
      r_meta       <= '0;
      r_head_shift <= '0;
      r_meta_shift <= '0;
      r_hit        <= 1'b0;
      r_state      <= IDLE;
    end else begin
      r_head <= w_head_out;
      r_meta <= w_meta_out;
      if (w1_lookup) begin
        r_head_shift <= r1_head_shift;
        r_meta_shift <= r1_meta_shift;
        r_hit        <= |r1_hits;
      end
      if (w1_valid) begin
        if (w1_start) begin
          r_state <= w1_tail ? IDLE : IN_PKT;
        end else if (w1_tail) begin
          r_state <= IDLE;
        end
      end
    end
  end

  assign bus.o_head      = r_head;
  assign bus.o_meta      = r_meta;
  assign bus.o_headShift = r_head_shift;
  assign bus.o_metaShift = r_meta_shift;
  assign bus.o_hit       = r_hit;

`ifdef HEAD_LOOKUP_STAT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w1_lookup) begin
      if (|r1_hits) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
`endif
endmodule
`default_nettype wire
